// File: rtl/fmac_pkg.sv
// Shared definitions for the fmac result path: FloPoCo word geometry, exception codes,
// and the one-hot state encoding of the result drain FSM.
package fmac_pkg;

    localparam int FMAC_WE = 8;
    localparam int FMAC_WF = 23;
    localparam int FMAC_W  = FMAC_WE + FMAC_WF + 3;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b01,
        S_DRAIN = 2'b10
    } drain_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fmac_result_drain_if.sv
// Result stream from the drain: one PE result per beat over valid/ready.
interface fmac_result_drain_if
    import fmac_pkg::*;
#(
    parameter int W     = FMAC_W,
    parameter int IDX_W = 2
);
    logic [W-1:0]     out_data;
    logic [IDX_W-1:0] out_pe_idx;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data, out_pe_idx, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_pe_idx, out_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/fp_exc_classify.sv
// Decodes the 2-bit FloPoCo exception field at the top of a result word.
module fp_exc_classify
    import fmac_pkg::*;
#(
    parameter int W = FMAC_W
) (
    input  logic [W-1:0] word,
    output logic         is_zero,
    output logic         is_normal,
    output logic         is_inf,
    output logic         is_nan
);
    logic [1:0] exc;

    assign exc       = word[W-1:W-2];
    assign is_zero   = (exc == EXC_ZERO);
    assign is_normal = (exc == EXC_NORMAL);
    assign is_inf    = (exc == EXC_INF);
    assign is_nan    = (exc == EXC_NAN);
endmodule

// File: rtl/fmac_result_drain.sv
// Snapshots all PE accumulators on the sequencer's done pulse and streams them out one per beat,
// keeping saturating NaN/Inf tallies so the fmac array can restart while results drain.
module fmac_result_drain
    import fmac_pkg::*;
#(
    parameter int WE      = FMAC_WE,
    parameter int WF      = FMAC_WF,
    parameter int NUM_PES = 4,
    localparam int W      = WE + WF + 3,
    localparam int IDX_W  = (NUM_PES > 1) ? $clog2(NUM_PES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   done,
    input  logic [NUM_PES*W-1:0]   pe_r,
    fmac_result_drain_if.master    drain,
    output logic                   busy,
    output logic                   overrun,
    output logic [15:0]            nan_count,
    output logic [15:0]            inf_count
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PES - 1);

    drain_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     snap_q [NUM_PES];
    logic             capture;
    logic             overrun_set;
    logic             valid;
    logic             fire;
    logic             is_last;
    logic             cls_zero, cls_normal, cls_inf, cls_nan;

    assign valid   = (state_q == S_DRAIN);
    assign fire    = valid && drain.out_ready;
    assign is_last = (idx_q == LAST_IDX);

    assign drain.out_valid  = valid;
    assign drain.out_data   = snap_q[idx_q];
    assign drain.out_pe_idx = idx_q;
    assign drain.out_last   = valid && is_last;
    assign busy             = valid;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        capture     = 1'b0;
        overrun_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (done) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fire) begin
                    if (is_last) begin
                        // A done landing exactly on the last beat chains the next drain with no bubble.
                        if (done) begin
                            capture = 1'b1;
                            idx_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                if (done && !(fire && is_last)) begin
                    overrun_set = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (overrun_set) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_PES; k++) begin
                snap_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < NUM_PES; k++) begin
                snap_q[k] <= pe_r[k*W +: W];
            end
        end
    end

    fp_exc_classify #(.W(W)) u_classify (
        .word      (drain.out_data),
        .is_zero   (cls_zero),
        .is_normal (cls_normal),
        .is_inf    (cls_inf),
        .is_nan    (cls_nan)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            nan_count <= '0;
            inf_count <= '0;
        end else if (fire) begin
            if (cls_nan) begin
                nan_count <= sat_inc16(nan_count);
            end
            if (cls_inf) begin
                inf_count <= sat_inc16(inf_count);
            end
        end
    end
endmodule

// File: tb/tb_fmac_result_drain.sv
// Randomized and directed checks of fmac_result_drain against a queue-based model of the beat stream.
module tb_fmac_result_drain;
    import fmac_pkg::*;

    localparam int NUM_PES = 4;
    localparam int W       = FMAC_W;
    localparam int IDX_W   = 2;

    localparam logic [W-1:0] ONE  = 34'h1_3F80_0000;
    localparam logic [W-1:0] PINF = 34'h2_0000_0000;
    localparam logic [W-1:0] QNAN = 34'h3_0000_0000;
    localparam logic [W-1:0] ZERO = 34'h0_0000_0000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 done;
    logic [NUM_PES*W-1:0] pe_r;
    logic                 busy;
    logic                 overrun;
    logic [15:0]          nan_count;
    logic [15:0]          inf_count;

    fmac_result_drain_if #(.W(W), .IDX_W(IDX_W)) s_if ();

    fmac_result_drain #(.WE(8), .WF(23), .NUM_PES(NUM_PES)) dut (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .pe_r      (pe_r),
        .drain     (s_if),
        .busy      (busy),
        .overrun   (overrun),
        .nan_count (nan_count),
        .inf_count (inf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           idx;
    } beat_t;

    beat_t        exp_q[$];
    int           m_nan, m_inf;
    bit           m_ovr;
    logic [W-1:0] pe_words [NUM_PES];
    int           n_cmp = 0;
    int           n_err = 0;
    int           dut_fires;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        bit has = (exp_q.size() > 0);
        check("out_valid", 64'(s_if.out_valid), 64'(has));
        check("busy", 64'(busy), 64'(has));
        if (has) begin
            check("out_data", 64'(s_if.out_data), 64'(exp_q[0].data));
            check("out_pe_idx", 64'(s_if.out_pe_idx), 64'(exp_q[0].idx));
            check("out_last", 64'(s_if.out_last), 64'(exp_q[0].idx == NUM_PES - 1));
        end
        check("nan_count", 64'(nan_count), 64'(m_nan));
        check("inf_count", 64'(inf_count), 64'(m_inf));
        check("overrun", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic model_update(input bit d, input bit r, input bit rst);
        bit         was_idle;
        bit         fire;
        bit         last_fire;
        logic [1:0] exc;
        beat_t      b;
        if (rst) begin
            exp_q.delete();
            m_nan = 0;
            m_inf = 0;
            m_ovr = 1'b0;
            return;
        end
        was_idle  = (exp_q.size() == 0);
        fire      = !was_idle && r;
        last_fire = fire && (exp_q.size() == 1);
        if (fire) begin
            exc = exp_q[0].data[W-1 -: 2];
            if (exc == 2'b11 && m_nan < 65535) m_nan++;
            if (exc == 2'b10 && m_inf < 65535) m_inf++;
            void'(exp_q.pop_front());
        end
        if (d) begin
            if (was_idle || last_fire) begin
                for (int k = 0; k < NUM_PES; k++) begin
                    b.data = pe_words[k];
                    b.idx  = k;
                    exp_q.push_back(b);
                end
            end else begin
                m_ovr = 1'b1;
            end
        end
    endtask

    // One clock: check what the DUT shows now, apply inputs, advance the model, take the edge.
    task automatic step(input bit d, input bit r, input bit rst);
        @(negedge clk);
        check_outputs();
        reset          = rst;
        done           = d;
        s_if.out_ready = r;
        for (int k = 0; k < NUM_PES; k++) pe_r[k*W +: W] = pe_words[k];
        if (!rst && s_if.out_valid && r) dut_fires++;
        model_update(d, r, rst);
        @(posedge clk);
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int k = 0; k < NUM_PES; k++) pe_words[k] = v;
    endtask

    task automatic set_random();
        for (int k = 0; k < NUM_PES; k++) pe_words[k] = {2'($urandom_range(3)), 32'($urandom)};
    endtask

    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int guard;

        reset = 1'b1;
        done = 1'b0;
        s_if.out_ready = 1'b0;
        pe_r = '0;
        set_all(ZERO);
        dut_fires = 0;
        model_update(1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // all 1.0, always ready
        set_all(ONE);
        step(1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        check("t1_idle_busy", 64'(busy), 64'(0));

        // stalled drain, ready pattern 1,0,0,1
        dut_fires = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, pat[i % 4], 1'b0);
        check("t2_fires", 64'(dut_fires), 64'(4));

        // exception tallies
        pe_words[3] = QNAN; pe_words[2] = PINF; pe_words[1] = ZERO; pe_words[0] = ONE;
        for (int rep = 0; rep < 3; rep++) begin
            step(1'b1, 1'b1, 1'b0);
            repeat (5) step(1'b0, 1'b1, 1'b0);
        end
        check("t3_nan", 64'(nan_count), 64'(3));
        check("t3_inf", 64'(inf_count), 64'(3));

        // done mid-drain is dropped and flagged
        set_all(ONE);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        set_random();
        step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        check("t4_overrun", 64'(overrun), 64'(1));

        // done on the last-beat fire chains a new drain
        step(1'b0, 1'b0, 1'b1);
        set_random();
        step(1'b1, 1'b1, 1'b0);
        guard = 0;
        while (exp_q.size() != 1 && guard < 10) begin
            step(1'b0, 1'b1, 1'b0);
            guard++;
        end
        check("t5_reach_last", 64'(exp_q.size()), 64'(1));
        set_random();
        step(1'b1, 1'b1, 1'b0);
        check("t5_chain_idx", 64'(exp_q[0].idx), 64'(0));
        repeat (5) step(1'b0, 1'b1, 1'b0);
        check("t5_overrun", 64'(overrun), 64'(0));

        // reset mid-drain
        set_all(QNAN);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("t6_nan_cleared", 64'(nan_count), 64'(0));
        set_all(PINF);
        step(1'b1, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            set_random();
            step(($urandom_range(5) == 0), ($urandom_range(9) < 7), ($urandom_range(299) == 0));
        end
        repeat (8) step(1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
